audio_pwm_out: RTL and testbench



---
 rtl/audio_pkg.sv | 6 +
 rtl/audio_pwm_out_if.sv | 12 +
 rtl/sample_fifo.sv | 43 ++++
 rtl/audio_pwm_out.sv | 68 ++++++
 tb/tb_audio_pwm_out.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared defaults and state type for the PWM audio output path.
package audio_pkg;
  localparam int SAMPLE_W_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  typedef enum logic {IDLE, RUN} pwm_state_t;
endpackage

// File: rtl/audio_pwm_out_if.sv
// audio_pwm_out_if: valid/ready sample push channel.
// in_data/in_valid flow from the master (sample producer).
// in_ready flows back from the slave (the PWM block's sample FIFO).
import audio_pkg::*;

interface audio_pwm_out_if #(parameter int SAMPLE_W = SAMPLE_W_DEF);
  logic [SAMPLE_W-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  modport master (output in_data, in_valid, input in_ready);
  modport slave  (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/sample_fifo.sv
// sample_fifo: in-order sample buffer with show-ahead read data.
// Ports: clk, reset_n (async, active-low), push/wr_data (write side),
// pop/rd_data (read side, rd_data valid whenever !empty), full, empty, level.
// Push while full and pop while empty are ignored.
import audio_pkg::*;

module sample_fifo #(
  parameter int W     = SAMPLE_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [W-1:0]               wr_data,
  input  logic                       pop,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  always_comb begin
    level   = wr_q - rd_q;
    empty   = wr_q == rd_q;
    full    = level == (AW+1)'(DEPTH);
    wr_d    = wr_q + (AW+1)'(push && !full);
    rd_d    = rd_q + (AW+1)'(pop && !empty);
    rd_data = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (push && !full) mem_q[wr_q[AW-1:0]] <= wr_data;
endmodule

// File: rtl/audio_pwm_out.sv
// audio_pwm_out: buffers PCM samples, pops one per sample_tick, renders PWM.
// Ports: clk, reset_n (async, active-low), sample_tick (audio-rate strobe),
// in_if (sample push channel, slave side), fifo_level (occupancy),
// pwm_out (registered PWM), underrun (1-cycle pulse on empty tick in RUN).
import audio_pkg::*;

module audio_pwm_out #(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sample_tick,
  audio_pwm_out_if.slave                in_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          pwm_out,
  output logic                          underrun
);
  logic                full, empty, pop;
  logic [SAMPLE_W-1:0] rd_data;
  pwm_state_t          st_q, st_d;
  logic [SAMPLE_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [SAMPLE_W-1:0] duty_pending_q, duty_pending_d;
  logic [SAMPLE_W-1:0] duty_active_q, duty_active_d;
  logic                pwm_q, pwm_d;
  logic                underrun_q, underrun_d;
  assign in_if.in_ready = !full;
  assign pwm_out        = pwm_q;
  assign underrun       = underrun_q;
  sample_fifo #(.W(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (in_if.in_valid),
    .wr_data (in_if.in_data),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );
  // An empty tick leaves duty_pending alone so the last sample repeats.
  // duty_active only follows duty_pending at the frame wrap, so no runt pulses.
  always_comb begin
    pop            = sample_tick && !empty;
    st_d           = pop ? RUN : st_q;
    duty_pending_d = pop ? rd_data : duty_pending_q;
    underrun_d     = sample_tick && empty && st_q == RUN;
    pwm_cnt_d      = pwm_cnt_q + 1'b1;
    duty_active_d  = &pwm_cnt_q ? duty_pending_q : duty_active_q;
    pwm_d          = pwm_cnt_q < duty_active_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st_q           <= IDLE;
      pwm_cnt_q      <= '0;
      duty_pending_q <= '0;
      duty_active_q  <= '0;
      pwm_q          <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      st_q           <= st_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_pending_q <= duty_pending_d;
      duty_active_q  <= duty_active_d;
      pwm_q          <= pwm_d;
      underrun_q     <= underrun_d;
    end
endmodule

// File: tb/tb_audio_pwm_out.sv
// tb_audio_pwm_out: random and directed stimulus against a queue-based model.
module tb_audio_pwm_out;
  import audio_pkg::*;
  localparam int W = 8, D = 4, N = 256;
  logic clk = 0, reset_n = 0, sample_tick = 0;
  logic [2:0] fifo_level;
  logic pwm_out, underrun;
  int tests = 0, fails = 0;
  audio_pwm_out_if #(.SAMPLE_W(W)) in_if();
  audio_pwm_out #(.SAMPLE_W(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .in_if(in_if),
    .fifo_level(fifo_level), .pwm_out(pwm_out), .underrun(underrun));
  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of samples, frame position from cycles since reset,
  // a sample becomes the duty at the first frame end after it is popped.
  int q[$];
  int m_cnt = 0, m_pend = 0, m_act = 0, m_pwm = 0, m_und = 0;
  bit m_run = 0, p_ok;
  always @(posedge clk) begin
    if (!reset_n) begin
      q.delete();
      m_cnt = 0; m_pend = 0; m_act = 0; m_pwm = 0; m_und = 0; m_run = 0;
    end else begin
      m_pwm = int'(m_cnt < m_act);
      if (m_cnt == N-1) m_act = m_pend;
      m_und = int'(sample_tick && q.size() == 0 && m_run);
      p_ok = in_if.in_valid && q.size() < D;
      if (sample_tick && q.size() > 0) begin
        m_pend = q.pop_front();
        m_run = 1;
      end
      if (p_ok) q.push_back(int'(in_if.in_data));
      m_cnt = (m_cnt + 1) % N;
    end
    #1;
    chk("pwm_out", pwm_out, m_pwm);
    chk("underrun", underrun, m_und);
    chk("fifo_level", fifo_level, q.size());
    chk("in_ready", in_if.in_ready, int'(q.size() < D));
  end

  task automatic drive(input bit v, input int d, input bit t);
    in_if.in_valid = v;
    in_if.in_data = W'(d);
    sample_tick = t;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0);
  endtask

  task automatic count_high(output int n);
    n = 0;
    repeat (N) begin
      drive(0, 0, 0);
      n += int'(pwm_out);
    end
  endtask

  int n;
  bit prev, t;
  initial begin
    in_if.in_valid = 0;
    in_if.in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", in_if.in_ready, 1);
    chk("rst_und", underrun, 0);
    chk("rst_st", int'(dut.st_q), int'(IDLE));
    reset_n = 1;
    repeat (5) begin
      drive(0, 0, 1);
      chk("idle_tick_und", underrun, 0);
      drive(0, 0, 0);
    end
    chk("idle_st", int'(dut.st_q), int'(IDLE));
    chk("idle_pwm", pwm_out, 0);
    chk("idle_ready", in_if.in_ready, 1);
    drive(1, 'h40, 0);
    chk("push40_level", fifo_level, 1);
    drive(0, 0, 1);
    chk("pop40_level", fifo_level, 0);
    chk("run_st", int'(dut.st_q), int'(RUN));
    idle(300);
    count_high(n);
    chk("duty40_high", n, 64);
    drive(1, 'h10, 0); drive(1, 'h20, 0); drive(1, 'h30, 0); drive(1, 'h40, 0);
    chk("full_level", fifo_level, 4);
    chk("full_ready", in_if.in_ready, 0);
    drive(1, 'h99, 0);
    chk("reject_level", fifo_level, 4);
    drive(1, 'h55, 1);
    chk("full_pop_level", fifo_level, 3);
    drive(1, 'h80, 0);
    chk("refill_level", fifo_level, 4);
    repeat (4) begin
      drive(0, 0, 1);
      drive(0, 0, 0);
    end
    chk("drained_level", fifo_level, 0);
    drive(0, 0, 1);
    chk("underrun_pulse", underrun, 1);
    drive(0, 0, 0);
    chk("underrun_end", underrun, 0);
    idle(300);
    count_high(n);
    chk("repeat80_high", n, 128);
    drive(1, 'h00, 0); drive(0, 0, 1);
    idle(300);
    count_high(n);
    chk("duty00_high", n, 0);
    drive(1, 'hFF, 0); drive(0, 0, 1);
    idle(300);
    count_high(n);
    chk("dutyFF_high", n, 255);
    prev = 0;
    for (int i = 0; i < 3000; i++) begin
      t = !prev && $urandom_range(0, 15) == 0;
      prev = t;
      drive(i < 1500 ? $urandom_range(0, 19) == 0 : $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 255)), t);
    end
    repeat (20) begin
      drive(0, 0, 1);
      drive(0, 0, 0);
    end
    chk("random_drained", fifo_level, 0);
    drive(1, 'hFF, 0); drive(0, 0, 1);
    idle(300);
    drive(1, 1, 0); drive(1, 2, 0); drive(1, 3, 0);
    chk("pre_rst_level", fifo_level, 3);
    for (int i = 0; i < 300 && m_cnt != 100; i++) drive(0, 0, 0);
    chk("pre_rst_pwm", pwm_out, 1);
    #2 reset_n = 0;
    #1;
    chk("async_rst_pwm", pwm_out, 0);
    chk("async_rst_level", fifo_level, 0);
    chk("async_rst_st", int'(dut.st_q), int'(IDLE));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    drive(0, 0, 1);
    chk("post_rst_und", underrun, 0);
    chk("post_rst_st", int'(dut.st_q), int'(IDLE));
    idle(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
